// File: rtl/store_buffer_if.sv
// +----------------------------------------------------------------------+
// | store_buffer_if : store request, load-forward and memory write bus    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface store_buffer_if;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic [31:0] st_pc;
  logic        st_ready;
  logic        st_err;
  logic [31:0] ld_addr;
  logic [31:0] dm_rdata;
  logic [31:0] ld_data;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_pc;
  logic        dm_ready;
  logic        empty;

  modport master (
    output st_valid, st_addr, st_data, st_size, st_pc, ld_addr, dm_rdata, dm_ready,
    input  st_ready, st_err, ld_data, dm_we, dm_addr, dm_wdata, dm_be, dm_pc, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_size, st_pc, ld_addr, dm_rdata, dm_ready,
    output st_ready, st_err, ld_data, dm_we, dm_addr, dm_wdata, dm_be, dm_pc, empty
  );
endinterface

`default_nettype wire

// File: rtl/store_buffer.sv
// +----------------------------------------------------------------------+
// | store_buffer : posted-write FIFO with byte-lane load forwarding       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  wire logic     clk,
  input  wire logic     reset,
  store_buffer_if.slave bus
);

  localparam logic [PTR_W:0] c_FULL = (PTR_W+1)'(DEPTH);

  logic [29:0]      r_waddr [DEPTH];
  logic [31:0]      r_wdata [DEPTH];
  logic [3:0]       r_be    [DEPTH];
  logic [31:0]      r_pc    [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;
  logic             r_err;

  logic             w_legal;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic             w_push;
  logic             w_pop;
  logic [31:0]      w_ld;
  logic [PTR_W-1:0] w_idx;
  logic             w_unused;

  // Store conversion: lane replication lets memory pick bytes by enable alone
  always_comb begin
    w_legal = 1'b1;
    w_be    = 4'b0000;
    w_wdata = bus.st_data;
    case (bus.st_size)
      2'b00: begin
        w_be    = 4'b0001 << bus.st_addr[1:0];
        w_wdata = {4{bus.st_data[7:0]}};
      end
      2'b01: begin
        w_be    = bus.st_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.st_data[15:0]}};
        w_legal = !bus.st_addr[0];
      end
      2'b10: begin
        w_be    = 4'b1111;
        w_legal = (bus.st_addr[1:0] == 2'b00);
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign bus.st_ready = (r_count != c_FULL);
  assign bus.st_err   = r_err;
  assign bus.empty    = (r_count == '0);
  assign bus.dm_we    = !bus.empty;
  assign bus.dm_addr  = {r_waddr[r_head], 2'b00};
  assign bus.dm_wdata = r_wdata[r_head];
  assign bus.dm_be    = r_be[r_head];
  assign bus.dm_pc    = r_pc[r_head];
  assign bus.ld_data  = w_ld;

  assign w_push   = bus.st_valid && bus.st_ready && w_legal;
  assign w_pop    = bus.dm_we && bus.dm_ready;
  assign w_unused = ^bus.ld_addr[1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= bus.st_valid && !w_legal;
      if (w_pop) begin
        r_head          <= r_head + 1'b1;
        r_valid[r_head] <= 1'b0;
      end
      if (w_push) begin
        r_tail          <= r_tail + 1'b1;
        r_valid[r_tail] <= 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_waddr[r_tail] <= bus.st_addr[31:2];
      r_wdata[r_tail] <= w_wdata;
      r_be[r_tail]    <= w_be;
      r_pc[r_tail]    <= bus.st_pc;
    end
  end

  // Walk from head (oldest) so younger matching entries overwrite older lanes
  always_comb begin
    w_ld  = bus.dm_rdata;
    w_idx = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if (r_valid[w_idx] && (r_waddr[w_idx] == bus.ld_addr[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (r_be[w_idx][b]) w_ld[8*b +: 8] = r_wdata[w_idx][8*b +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// +----------------------------------------------------------------------+
// | tb_store_buffer : directed vector table plus reset/drain sequences    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_store_buffer;

  logic clk = 1'b0;
  logic reset;

  store_buffer_if bus();

  store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        v;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
    logic [31:0] la;
    logic [31:0] rd;
    logic        rdy;
    logic        e_ready;
    logic        e_err;
    logic        e_empty;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic        chk_ld;
    logic [31:0] e_ld;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] mem [0:1023];

  // Word memory model; dm_rdata comes from the vector table, not from here
  always @(posedge clk) begin
    logic [31:0] merged;
    if (bus.dm_we && bus.dm_ready) begin
      merged = bus.dm_rdata;
      for (int b = 0; b < 4; b++) begin
        if (bus.dm_be[b]) begin
          merged[8*b +: 8] = bus.dm_wdata[8*b +: 8];
          mem[bus.dm_addr[11:2]][8*b +: 8] = bus.dm_wdata[8*b +: 8];
        end
      end
      $display("@%h: *%h <= %h", bus.dm_pc, bus.dm_addr, merged);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic v, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz, input logic [31:0] la, input logic [31:0] rd,
                     input logic rdy, input logic e_ready, input logic e_err, input logic e_empty,
                     input logic e_we, input logic [31:0] e_addr, input logic [31:0] e_wdata,
                     input logic [3:0] e_be, input logic chk_ld, input logic [31:0] e_ld);
    vec_t t;
    t.rst = rst; t.v = v; t.a = a; t.d = d; t.sz = sz; t.la = la; t.rd = rd; t.rdy = rdy;
    t.e_ready = e_ready; t.e_err = e_err; t.e_empty = e_empty; t.e_we = e_we;
    t.e_addr = e_addr; t.e_wdata = e_wdata; t.e_be = e_be; t.chk_ld = chk_ld; t.e_ld = e_ld;
    tbl.push_back(t);
  endtask

  task automatic idle_inputs();
    bus.st_valid = 1'b0;
    bus.st_addr  = '0;
    bus.st_data  = '0;
    bus.st_size  = 2'b00;
    bus.st_pc    = '0;
    bus.ld_addr  = '0;
    bus.dm_rdata = '0;
  endtask

  task automatic push_sw(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.st_valid = 1'b1;
    bus.st_addr  = a;
    bus.st_data  = d;
    bus.st_size  = 2'b10;
    bus.st_pc    = 32'h2000 + a;
  endtask

  initial begin
    int budget;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    idle_inputs();
    bus.dm_ready = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Single word store and drain
    add(0,0,0,0,0,           32'h10,0,1, 1,0,1,0, 0,0,0,                    1,0);
    add(0,1,32'h10,32'h11223344,2, 32'h10,0,1, 1,0,1,0, 0,0,0,              1,0);
    add(0,0,0,0,0,           32'h10,0,1, 1,0,0,1, 32'h10,32'h11223344,4'hF, 1,32'h11223344);
    add(0,0,0,0,0,           32'h10,0,1, 1,0,1,0, 0,0,0,                    1,0);
    // Byte then half to the same word, forwarding overlap
    add(0,1,32'h13,32'hAB,0, 32'h10,0,0, 1,0,1,0, 0,0,0,                    1,0);
    add(0,1,32'h12,32'hBEEF,1, 32'h10,0,0, 1,0,0,1, 32'h10,32'hABABABAB,4'h8, 1,32'hAB000000);
    add(0,0,0,0,0, 32'h10,32'h55667788,0, 1,0,0,1, 32'h10,32'hABABABAB,4'h8, 1,32'hBEEF7788);
    add(0,0,0,0,0, 32'h14,32'h55667788,0, 1,0,0,1, 32'h10,32'hABABABAB,4'h8, 1,32'h55667788);
    add(0,0,0,0,0, 32'h10,0,1, 1,0,0,1, 32'h10,32'hABABABAB,4'h8,           1,32'hBEEF0000);
    add(0,0,0,0,0, 32'h10,0,1, 1,0,0,1, 32'h10,32'hBEEFBEEF,4'hC,           1,32'hBEEF0000);
    add(0,0,0,0,0, 32'h10,32'h12345678,1, 1,0,1,0, 0,0,0,                   1,32'h12345678);
    // Misaligned and illegal stores
    add(0,1,32'h21,32'h1111,1, 0,0,1, 1,0,1,0, 0,0,0, 0,0);
    add(0,1,32'h22,32'h2222,2, 0,0,1, 1,1,1,0, 0,0,0, 0,0);
    add(0,0,0,0,0,             0,0,1, 1,1,1,0, 0,0,0, 0,0);
    add(0,1,32'h30,32'h3333,3, 0,0,1, 1,0,1,0, 0,0,0, 0,0);
    add(0,0,0,0,0,             0,0,1, 1,1,1,0, 0,0,0, 0,0);
    add(0,0,0,0,0,             0,0,1, 1,0,1,0, 0,0,0, 0,0);
    // Fill with memory stalled; fifth store refused
    add(0,1,32'h100,32'hA0A0A0A0,2, 0,0,0, 1,0,1,0, 0,0,0, 0,0);
    add(0,1,32'h101,32'h5A,0,       0,0,0, 1,0,0,1, 32'h100,32'hA0A0A0A0,4'hF, 0,0);
    add(0,1,32'h106,32'h1234,1,     0,0,0, 1,0,0,1, 32'h100,32'hA0A0A0A0,4'hF, 0,0);
    add(0,1,32'h108,32'hDEADBEEF,2, 0,0,0, 1,0,0,1, 32'h100,32'hA0A0A0A0,4'hF, 0,0);
    add(0,1,32'h10C,32'hCAFEF00D,2, 0,0,0, 0,0,0,1, 32'h100,32'hA0A0A0A0,4'hF, 0,0);
    add(0,0,0,0,0, 32'h104,0,0, 0,0,0,1, 32'h100,32'hA0A0A0A0,4'hF, 1,32'h12340000);
    add(0,0,0,0,0, 0,0,1, 0,0,0,1, 32'h100,32'hA0A0A0A0,4'hF, 0,0);
    add(0,0,0,0,0, 0,0,1, 1,0,0,1, 32'h100,32'h5A5A5A5A,4'h2, 0,0);
    add(0,0,0,0,0, 0,0,1, 1,0,0,1, 32'h104,32'h12341234,4'hC, 0,0);
    add(0,0,0,0,0, 0,0,1, 1,0,0,1, 32'h108,32'hDEADBEEF,4'hF, 0,0);
    add(0,0,0,0,0, 0,0,1, 1,0,1,0, 0,0,0,                     0,0);
    // Full with simultaneous push offer and pop, then push/pop while not full
    add(0,1,32'h200,1,2, 0,0,0, 1,0,1,0, 0,0,0,          0,0);
    add(0,1,32'h204,2,2, 0,0,0, 1,0,0,1, 32'h200,1,4'hF, 0,0);
    add(0,1,32'h208,3,2, 0,0,0, 1,0,0,1, 32'h200,1,4'hF, 0,0);
    add(0,1,32'h20C,4,2, 0,0,0, 1,0,0,1, 32'h200,1,4'hF, 0,0);
    add(0,1,32'h210,5,2, 0,0,1, 0,0,0,1, 32'h200,1,4'hF, 0,0);
    add(0,1,32'h210,5,2, 0,0,0, 1,0,0,1, 32'h204,2,4'hF, 0,0);
    add(0,0,0,0,0,       0,0,0, 0,0,0,1, 32'h204,2,4'hF, 0,0);
    add(0,0,0,0,0,       0,0,1, 0,0,0,1, 32'h204,2,4'hF, 0,0);
    add(0,1,32'h214,6,2, 0,0,1, 1,0,0,1, 32'h208,3,4'hF, 0,0);
    add(0,0,0,0,0,       0,0,1, 1,0,0,1, 32'h20C,4,4'hF, 0,0);
    add(0,0,0,0,0,       0,0,1, 1,0,0,1, 32'h210,5,4'hF, 0,0);
    add(0,0,0,0,0,       0,0,1, 1,0,0,1, 32'h214,6,4'hF, 0,0);
    add(0,0,0,0,0,       0,0,1, 1,0,1,0, 0,0,0,          0,0);

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      reset        = tbl[k].rst;
      bus.st_valid = tbl[k].v;
      bus.st_addr  = tbl[k].a;
      bus.st_data  = tbl[k].d;
      bus.st_size  = tbl[k].sz;
      bus.st_pc    = 32'h1000 + 32'(k * 4);
      bus.ld_addr  = tbl[k].la;
      bus.dm_rdata = tbl[k].rd;
      bus.dm_ready = tbl[k].rdy;
      #1;
      chk($sformatf("v%0d st_ready", k), 32'(bus.st_ready), 32'(tbl[k].e_ready));
      chk($sformatf("v%0d st_err", k),   32'(bus.st_err),   32'(tbl[k].e_err));
      chk($sformatf("v%0d empty", k),    32'(bus.empty),    32'(tbl[k].e_empty));
      chk($sformatf("v%0d dm_we", k),    32'(bus.dm_we),    32'(tbl[k].e_we));
      if (tbl[k].e_we) begin
        chk($sformatf("v%0d dm_addr", k),  bus.dm_addr,  tbl[k].e_addr);
        chk($sformatf("v%0d dm_wdata", k), bus.dm_wdata, tbl[k].e_wdata);
        chk($sformatf("v%0d dm_be", k),    32'(bus.dm_be), 32'(tbl[k].e_be));
      end
      if (tbl[k].chk_ld) chk($sformatf("v%0d ld_data", k), bus.ld_data, tbl[k].e_ld);
    end

    // Bounded drain of two stores with memory ready
    push_sw(32'h40, 32'h600DF00D);
    push_sw(32'h44, 32'h0000C0DE);
    bus.dm_ready = 1'b1;
    @(negedge clk);
    idle_inputs();
    budget = 0;
    while (!bus.empty && budget < 10) begin
      @(negedge clk);
      budget++;
    end
    n_cmp++;
    if (!bus.empty) begin
      n_bad++;
      $display("FAIL drain_timeout: empty=%0d after %0d cycles, required 1", bus.empty, budget);
    end

    // Reset with three stores pending discards them
    bus.dm_ready = 1'b0;
    push_sw(32'h300, 32'h77000000);
    push_sw(32'h304, 32'h77000001);
    push_sw(32'h308, 32'h77000002);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("pre_reset empty", 32'(bus.empty), 32'd0);
    chk("pre_reset dm_we", 32'(bus.dm_we), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.dm_ready = 1'b1;
    #1;
    chk("post_reset dm_we",    32'(bus.dm_we),    32'd0);
    chk("post_reset empty",    32'(bus.empty),    32'd1);
    chk("post_reset st_ready", 32'(bus.st_ready), 32'd1);
    chk("post_reset st_err",   32'(bus.st_err),   32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post_reset idle%0d dm_we", i), 32'(bus.dm_we), 32'd0);
    end

    // Memory contents after all drains
    chk("mem 0x010", mem[32'h010 >> 2], 32'hBEEF3344);
    chk("mem 0x020", mem[32'h020 >> 2], 32'h00000000);
    chk("mem 0x030", mem[32'h030 >> 2], 32'h00000000);
    chk("mem 0x040", mem[32'h040 >> 2], 32'h600DF00D);
    chk("mem 0x044", mem[32'h044 >> 2], 32'h0000C0DE);
    chk("mem 0x100", mem[32'h100 >> 2], 32'hA0A05AA0);
    chk("mem 0x104", mem[32'h104 >> 2], 32'h12340000);
    chk("mem 0x108", mem[32'h108 >> 2], 32'hDEADBEEF);
    chk("mem 0x10C", mem[32'h10C >> 2], 32'h00000000);
    for (int i = 0; i < 6; i++)
      chk($sformatf("mem 0x2%0h", 4 * i), mem[(32'h200 >> 2) + i], 32'(i + 1));
    chk("mem 0x300", mem[32'h300 >> 2], 32'h00000000);
    chk("mem 0x304", mem[32'h304 >> 2], 32'h00000000);
    chk("mem 0x308", mem[32'h308 >> 2], 32'h00000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write FIFO between the execute/memory stage and the word-addressed data memory.
- Accepts sb/sh/sw stores and converts each to a word address, lane-aligned write data and a 4-bit byte enable.
- Drains one store per cycle into the data memory.
- Merges pending store bytes over the memory's combinational read data, so loads see program-order-correct values without stalling.

Parameters:
- DEPTH, 4: number of buffer entries; power of two, 2..16.
- PTR_W, 2: log2(DEPTH).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- st_valid  in  1  store request this cycle.
- st_addr  in  32  byte address of store.
- st_data  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- st_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- st_pc  in  32  PC of the store, carried for the $display trace.
- st_ready  out  1  buffer can accept a store this cycle.
- st_err  out  1  registered one-cycle pulse: last offered store was misaligned or illegal and was dropped.
- ld_addr  in  32  byte address of the current load.
- dm_rdata  in  32  combinational word read from memory at ld_addr[11:2].
- ld_data  out  32  dm_rdata with pending store bytes merged in.
- dm_we  out  1  write strobe to memory.
- dm_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- dm_wdata  out  32  lane-aligned write data.
- dm_be  out  4  byte enables; bit i enables bits [8i+7:8i].
- dm_pc  out  32  PC of the draining store.
- dm_ready  in  1  memory accepts the write this cycle.
- empty  out  1  no pending stores.

Behaviour:
- Reset (clk edge with reset=1):
  - count, head and tail cleared; all entry valid bits cleared.
  - st_err=0.
  - Combinational outputs then read st_ready=1, empty=1, dm_we=0; dm_addr/dm_wdata/dm_be/dm_pc show entry 0 contents, which the consumer ignores.
  - Reset mid-drain discards all pending stores; no write is issued after the edge.
- Store conversion (combinational, before enqueue):
  - byte: be = 1<<addr[1:0]; wdata = {4{st_data[7:0]}}.
  - half: be = addr[1] ? 1100 : 0011; wdata = {2{st_data[15:0]}}.
  - word: be = 1111; wdata = st_data.
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned or size 11: not enqueued; st_err=1 next cycle.
- Enqueue:
  - Occurs on a clk edge when st_valid && st_ready && the store is legal.
  - st_ready = (count != DEPTH), purely from state.
  - No same-cycle bypass when full: a store offered while full is not taken, even if a drain occurs that cycle.
- Drain:
  - dm_we = !empty; dm_* driven combinationally from the head entry.
  - Pop on a clk edge when dm_we && dm_ready.
  - A store enqueued at edge N appears on dm_* in cycle N+1 at the earliest (1-cycle latency).
  - Simultaneous enqueue and pop: count unchanged; head and tail both advance.
  - Pointers wrap modulo DEPTH.
- Forwarding (combinational):
  - For each byte lane, ld_data lane = the youngest valid entry with matching addr[31:2] and that lane enabled; otherwise the dm_rdata lane.
  - Evaluate oldest to youngest so younger entries override.
  - The head entry being written this cycle still forwards (memory updates at the edge).
- Trace: on each pop, $display("@%h: *%h <= %h", dm_pc, dm_addr, merged word), where merged word = dm_rdata with the be lanes replaced. This is valid only when ld_addr maps to the same word; the bench checks memory contents instead.
- empty = (count==0).

Test Plan:
- Reset then sw 0x11223344 @0x10 with dm_ready=1 -> next cycle dm_we=1, dm_addr=0x10, dm_be=1111, dm_wdata=0x11223344; empty=1 after the pop.
- sb 0xAB @0x13, then sh 0xBEEF @0x12, with dm_ready=0 and dm_rdata=0 at ld_addr 0x10 -> ld_data=0xBEEF0000; the half overrides the earlier byte.
- Hold dm_ready=0 and push 5 legal stores -> st_ready=0 after the 4th; the 5th is not taken. Release dm_ready -> 4 writes issued in program order, one per cycle.
- Full buffer with push offered and pop in the same cycle -> pop happens, push refused; the next cycle the push is accepted and count=4.
- sh @0x21 and sw @0x22 -> st_err pulses one cycle each; nothing enqueued; empty stays 1.
- Reset asserted with 3 pending stores -> dm_we=0 the next cycle, empty=1, and no further writes.
